// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, width defaults and opcodes for the SPI slave
package spi_pkg;

  localparam int IN_WIDTH_DEF  = 10;
  localparam int OUT_WIDTH_DEF = 8;

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } spi_state_t;

  // Progress of the MISO reply inside READ_DATA.
  typedef enum logic [1:0] {
    TX_WAIT  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_DONE  = 2'd2
  } tx_phase_t;

endpackage

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - serial pins plus RAM-side word handshake of the SPI slave
interface spi_slave_if #(
  parameter int IN_WIDTH  = 10,
  parameter int OUT_WIDTH = 8
);

  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;
  logic [IN_WIDTH-1:0]  rx_data;
  logic                 rx_valid;
  logic [OUT_WIDTH-1:0] tx_data;
  logic                 tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_shift_rx.sv
// rtl/spi_shift_rx.sv - serial-to-parallel word capture with bit counter and done flag
module spi_shift_rx #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             mosi,
  output logic [WIDTH-1:0] word,
  output logic             strobe,
  output logic             done,
  output logic             last_bit
);

  logic [WIDTH-2:0] shreg;
  logic [3:0]       bit_cnt;

  // High on the edge that samples the final bit; lets the FSM act in the same cycle.
  assign last_bit = shift_en && !done && (bit_cnt == 4'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      word    <= '0;
      strobe  <= 1'b0;
      done    <= 1'b0;
    end else if (clear) begin
      shreg   <= '0;
      bit_cnt <= '0;
      strobe  <= 1'b0;
      done    <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (shift_en && !done) begin
        shreg <= {shreg[WIDTH-3:0], mosi};
        if (last_bit) begin
          word    <= {shreg, mosi};
          strobe  <= 1'b1;
          done    <= 1'b1;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave front end for a RAM; assertions under SPI_SLAVE_SVA_EN
module spi_slave
  import spi_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
  input logic        clk,
  input logic        rst_n,
  spi_slave_if.slave bus
);

  localparam int TXC_W = $clog2(OUT_WIDTH);

  spi_state_t           state;
  tx_phase_t            tx_phase;
  logic                 rd_addr_done;
  logic                 miso_q;
  logic [OUT_WIDTH-2:0] tx_sh;
  logic [TXC_W-1:0]     tx_cnt;

  logic shift_en;
  logic rx_strobe;
  logic rx_done;
  logic rx_last;

  assign shift_en = !bus.SS_n &&
                    (state == WRITE || state == READ_ADD || state == READ_DATA);

  spi_shift_rx #(
    .WIDTH(IN_WIDTH)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (bus.SS_n),
    .shift_en (shift_en),
    .mosi     (bus.MOSI),
    .word     (bus.rx_data),
    .strobe   (rx_strobe),
    .done     (rx_done),
    .last_bit (rx_last)
  );

  assign bus.rx_valid = rx_strobe;
  assign bus.MISO     = miso_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      tx_phase     <= TX_WAIT;
      rd_addr_done <= 1'b0;
      miso_q       <= 1'b0;
      tx_sh        <= '0;
      tx_cnt       <= '0;
    end else if (bus.SS_n) begin
      // Frame end: rd_addr_done survives so a read address can pair with the next frame.
      state    <= IDLE;
      tx_phase <= TX_WAIT;
      miso_q   <= 1'b0;
      tx_sh    <= '0;
      tx_cnt   <= '0;
    end else begin
      case (state)
        IDLE:     state <= CHK_CMD;
        CHK_CMD: begin
          if (!bus.MOSI)        state <= WRITE;
          else if (rd_addr_done) state <= READ_DATA;
          else                   state <= READ_ADD;
        end
        WRITE:    state <= WRITE;
        READ_ADD: begin
          if (rx_last) rd_addr_done <= 1'b1;
        end
        READ_DATA: begin
          case (tx_phase)
            TX_WAIT: begin
              if (rx_done && bus.tx_valid) begin
                miso_q   <= bus.tx_data[OUT_WIDTH-1];
                tx_sh    <= bus.tx_data[OUT_WIDTH-2:0];
                tx_cnt   <= '0;
                tx_phase <= TX_SHIFT;
              end
            end
            TX_SHIFT: begin
              if (tx_cnt == TXC_W'(OUT_WIDTH - 1)) begin
                miso_q       <= 1'b0;
                rd_addr_done <= 1'b0;
                tx_phase     <= TX_DONE;
              end else begin
                miso_q <= tx_sh[OUT_WIDTH-2];
                tx_sh  <= {tx_sh[OUT_WIDTH-3:0], 1'b0};
                tx_cnt <= tx_cnt + 1'b1;
              end
            end
            default: miso_q <= 1'b0;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_SVA_EN
  a_rx_valid_pulse : assert property (@(posedge clk) disable iff (!rst_n)
    bus.rx_valid |=> !bus.rx_valid);

  a_ss_high_idle : assert property (@(posedge clk)
    (rst_n && bus.SS_n) |=> (state == IDLE));

  a_miso_quiet : assert property (@(posedge clk) disable iff (!rst_n)
    bus.MISO |-> (state == READ_DATA && tx_phase == TX_SHIFT));
`else
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - randomized frame-level checks of spi_slave against a transaction model
module tb_spi_slave;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  // Frame-level model state: what the RAM side should see.
  logic       m_rd_done = 1'b0;
  logic [9:0] m_rx_data = '0;

  spi_slave_if #(.IN_WIDTH(10), .OUT_WIDTH(8)) bus ();

  spi_slave #(.IN_WIDTH(10), .OUT_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
    check({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
    check({tag, "_miso"}, 32'(bus.MISO), 32'd0);
    check({tag, "_rd_done"}, 32'(dut.rd_addr_done), 32'(m_rd_done));
    check({tag, "_rx_data"}, 32'(bus.rx_data), 32'(m_rx_data));
  endtask

  // One SS_n-low frame. Cycle k is the k-th edge after SS_n goes low (k=0 enters the frame).
  // nbits<10 aborts after that many payload bits; rst_bit>0 resets while that MISO bit is shown.
  task automatic run_frame(input string tag, input bit cmd, input logic [9:0] word,
                           input int nbits, input int tx_delay, input logic [7:0] tx_byte,
                           input int extra, input int rst_bit);
    int   kind;
    bit   full;
    int   cap;
    int   last;
    bit   was_reset;
    logic exp_miso;
    kind = (cmd == 1'b0) ? 0 : (m_rd_done ? 2 : 1);
    full = (nbits >= 10);
    cap  = 11 + tx_delay;
    last = !full ? 1 + nbits : ((kind == 2) ? cap + 8 + extra : 11 + extra);
    was_reset = 1'b0;
    for (int k = 0; k <= last + 1; k++) begin
      bus.SS_n = (k > last);
      if (k == 1)                bus.MOSI = cmd;
      else if (k >= 2 && k <= 11) bus.MOSI = word[11-k];
      else                       bus.MOSI = 1'($urandom);
      if (kind == 2 && k >= 12) bus.tx_valid = (k == cap);
      else                      bus.tx_valid = 1'($urandom);
      bus.tx_data = (kind == 2 && k == cap) ? tx_byte : 8'($urandom);
      if (rst_bit > 0 && k == cap + rst_bit) rst_n = 1'b0;
      tick();
      if (!rst_n) begin
        m_rd_done = 1'b0;
        m_rx_data = '0;
        check_idle({tag, "_rst"});
        rst_n = 1'b1;
        was_reset = 1'b1;
        break;
      end
      if (k > last) begin
        check_idle({tag, "_end"});
      end else begin
        if (full && k == 11) begin
          m_rx_data = word;
          if (kind == 1) m_rd_done = 1'b1;
        end
        if (kind == 2 && full && k == cap + 8) m_rd_done = 1'b0;
        exp_miso = (kind == 2 && full && k >= cap && k <= cap + 7) ? tx_byte[7-(k-cap)] : 1'b0;
        check({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'(full && k == 11));
        check({tag, "_rx_data"}, 32'(bus.rx_data), 32'(m_rx_data));
        check({tag, "_miso"}, 32'(bus.MISO), 32'(exp_miso));
        check({tag, "_rd_done"}, 32'(dut.rd_addr_done), 32'(m_rd_done));
      end
    end
    bus.SS_n = 1'b1;
    bus.tx_valid = 1'b0;
    tick();
    check_idle(was_reset ? {tag, "_post_rst"} : {tag, "_gap"});
  endtask

  initial begin
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    rst_n        = 1'b0;
    tick();
    tick();
    check_idle("reset");
    rst_n = 1'b1;
    tick();
    check_idle("after_reset");

    run_frame("wr_addr", 1'b0, {WR_ADDR, 8'h05}, 10, 1, 8'h00, 2, 0);
    run_frame("wr_data", 1'b0, {WR_DATA, 8'hAA}, 10, 1, 8'h00, 3, 0);
    run_frame("rd_addr", 1'b1, {RD_ADDR, 8'h0F}, 10, 1, 8'h00, 1, 0);
    run_frame("rd_data", 1'b1, {RD_DATA, 8'h00}, 10, 2, 8'hC3, 2, 0);
    run_frame("abort5", 1'b0, 10'h155, 5, 1, 8'h00, 0, 0);
    run_frame("after_abort", 1'b0, {WR_DATA, 8'h3C}, 10, 1, 8'h00, 0, 0);
    run_frame("rd_addr2", 1'b1, {RD_ADDR, 8'h44}, 10, 1, 8'h00, 0, 0);
    run_frame("rst_shift", 1'b1, {RD_DATA, 8'h00}, 10, 1, 8'hA5, 1, 4);
    run_frame("post_rst_wr", 1'b0, {WR_ADDR, 8'h81}, 10, 1, 8'h00, 0, 0);

    for (int i = 0; i < 30; i++) begin
      run_frame("rand", 1'($urandom), 10'($urandom),
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : 10,
                int'($urandom_range(1, 4)), 8'($urandom), int'($urandom_range(0, 3)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 10: width of the word sent to RAM (2-bit opcode plus 8-bit payload).
REQ-002 The block SHALL have parameter OUT_WIDTH, default 8: width of read data returned by RAM.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-005 The block SHALL have port SS_n, input, 1, active-low slave select; high ends a frame.
REQ-006 The block SHALL have port MOSI, input, 1, serial data in, sampled on each clk rising edge.
REQ-007 The block SHALL have port MISO, output, 1, serial read data, MSB first.
REQ-008 The block SHALL have port rx_data, output, IN_WIDTH, parallel word to RAM din.
REQ-009 The block SHALL have port rx_valid, output, 1, one-cycle strobe qualifying rx_data.
REQ-010 The block SHALL have port tx_data, input, OUT_WIDTH, RAM dout.
REQ-011 The block SHALL have port tx_valid, input, 1, qualifies tx_data.

Function
REQ-012 The FSM SHALL have the states IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA.
REQ-013 IDLE SHALL go to CHK_CMD on the first edge at which SS_n=0.
REQ-014 CHK_CMD SHALL sample MOSI as the command bit: 0 -> WRITE; 1 with rd_addr_done=0 -> READ_ADD; 1 with rd_addr_done=1 -> READ_DATA.
REQ-015 In WRITE, READ_ADD and READ_DATA the block SHALL shift the next 10 MOSI bits MSB-first into a shift register using a 4-bit bit counter.
REQ-016 On the edge that samples the 10th bit, the block SHALL load rx_data and assert rx_valid for exactly one cycle, so rx_valid is high in the 13th cycle after the SS_n-low edge.
REQ-017 A completed frame in READ_ADD SHALL set rd_addr_done=1.
REQ-018 In READ_DATA, after rx_valid, the block SHALL wait for tx_valid=1, capture tx_data, then drive its 8 bits on MISO over the next 8 cycles, MSB first.
REQ-019 After the 8th MISO bit the block SHALL clear rd_addr_done, drive MISO to 0 and hold the state.
REQ-020 tx_valid SHALL be ignored in every state other than READ_DATA-after-rx_valid.
REQ-021 MOSI bits beyond the 10th SHALL be ignored, with no second rx_valid, until SS_n returns high.
REQ-022 SS_n=1 in any state SHALL, on that edge, force IDLE, clear the counter and shift register, drive rx_valid=0 and MISO=0, and preserve rd_addr_done.
REQ-023 A frame aborted before its 10th bit SHALL produce no rx_valid and SHALL leave rd_addr_done unchanged.
REQ-024 rx_data SHALL hold its last value between strobes.

Reset
REQ-025 When rst_n=0 at a clk edge, the block SHALL set state=IDLE, rx_data=0, rx_valid=0, MISO=0, rd_addr_done=0 and all counters and shift registers to 0.
REQ-026 Reset SHALL take priority over SS_n and abort any frame, including MISO shift-out.

Configuration
REQ-027 With SPI_SLAVE_SVA_EN defined, the block SHALL compile in concurrent assertions: rx_valid is never high two consecutive cycles; state is IDLE one cycle after SS_n=1 when rst_n=1; MISO=0 outside READ_DATA shift-out.
REQ-028 Without SPI_SLAVE_SVA_EN, no assertion code SHALL be compiled and the RTL function SHALL be identical.

Structure
REQ-029 A shared package spi_pkg SHALL hold the state enum typedef, the IN_WIDTH and OUT_WIDTH defaults, and opcode constants WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11.
REQ-030 Sub-module spi_shift_rx SHALL contain the serial-to-parallel register, the bit counter and the done flag; the FSM and MISO logic SHALL stay in spi_slave.

Verification
REQ-031 Write address: SS_n low, MOSI 0 then 00_0000_0101 -> rx_valid single pulse with rx_data=10'h005 in cycle 13.
REQ-032 Write data: command 0, bits 01_1010_1010 -> rx_data=10'h1AA and no MISO activity.
REQ-033 Read pair: command 1 + 10'h2_0F -> rd_addr_done=1; new frame, command 1 + 10'h3_00, tx_valid with tx_data=8'hC3 -> MISO 1,1,0,0,0,0,1,1 and rd_addr_done=0.
REQ-034 Abort: SS_n high after 5 write bits -> no rx_valid, state IDLE next cycle, and the next full frame decodes correctly.
REQ-035 Reset mid shift-out: rst_n=0 during the 4th MISO bit -> MISO=0, state IDLE and rd_addr_done=0 on that edge.
REQ-036 Spurious tx_valid=1 during WRITE -> no MISO toggling.
